// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle for the sequential divider div_seq.
// The master drives the request and operands. The slave (the divider) returns
// the results and status.
interface div_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] m_in;
  logic [WIDTH-1:0] n_in;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, m_in, n_in,
    input  quot, rem, busy, done, dz
  );

  modport slave (
    input  start, m_in, n_in,
    output quot, rem, busy, done, dz
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider that produces one quotient bit per clock.
// This is the companion of the shift-add multiplier and uses the same start/busy
// handshake. An operation launches on a rising edge of start while the divider
// is idle. quot/rem/dz update only when an operation completes, and done pulses
// for one cycle at that point.
// Optional build macro DIV_SIGNED_EN: when defined, the operands are two's
// complement. The magnitudes are divided, and one extra FIX cycle then applies
// the signs with truncation toward zero.
module div_seq #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t           state, state_nxt;
  logic             start_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dz_q;

  // Iteration datapath. The partial remainder never reaches the divisor, so
  // WIDTH bits are enough to hold it between iterations.
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH:0]   r_shift, r_try;
  logic             fits;
  logic [WIDTH-1:0] q_nxt, r_nxt;
  logic             launch;

`ifdef DIV_SIGNED_EN
  logic m_neg;
  logic q_neg;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
`endif

  assign launch = bus.start & ~start_q & ~busy_q;

  // Trial subtraction for one restoring step.
  always_comb begin
    r_shift = {r_reg, q_sh[WIDTH-1]};
    r_try   = r_shift - {1'b0, d_reg};
    fits    = ~r_try[WIDTH];
    q_nxt   = {q_sh[WIDTH-2:0], fits};
    r_nxt   = fits ? r_try[WIDTH-1:0] : r_shift[WIDTH-1:0];
  end

  // Next-state decode: idle until launch, run WIDTH iterations, then finish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
`ifdef DIV_SIGNED_EN
      RUN:  if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
`else
      RUN:  if (cnt == LAST) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake, iteration counter and the visible result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      done_q  <= 1'b0;
      if (launch) begin
        busy_q <= 1'b1;
        cnt    <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
`ifndef DIV_SIGNED_EN
        if (cnt == LAST) begin
          quot_q <= q_nxt;
          rem_q  <= r_nxt;
          dz_q   <= (d_reg == '0);
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
`endif
      end
`ifdef DIV_SIGNED_EN
      else if (state == FIX) begin
        // A zero divisor reports all ones regardless of the sign of the dividend.
        // Negating |m| restores m_in as the remainder.
        quot_q <= (d_reg == '0) ? '1 : apply_sign(q_sh, q_neg);
        rem_q  <= apply_sign(r_reg, m_neg);
        dz_q   <= (d_reg == '0);
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
`endif
    end
  end

  // Operand capture on launch, then one shift/subtract step per RUN cycle.
  always_ff @(posedge clk) begin
    if (launch) begin
`ifdef DIV_SIGNED_EN
      q_sh  <= mag(bus.m_in);
      d_reg <= mag(bus.n_in);
      m_neg <= bus.m_in[WIDTH-1];
      q_neg <= bus.m_in[WIDTH-1] ^ bus.n_in[WIDTH-1];
`else
      q_sh  <= bus.m_in;
      d_reg <= bus.n_in;
`endif
      r_reg <= '0;
    end else if (state == RUN) begin
      q_sh  <= q_nxt;
      r_reg <= r_nxt;
    end
  end

  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq: handshake, latency, results and reset abort.
// The bench drives inputs and samples outputs on falling clock edges.
`timescale 1ns/1ps
module tb_div_seq;
  localparam int WIDTH = 16;
`ifdef DIV_SIGNED_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  div_seq_if #(.WIDTH(WIDTH)) bus ();

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Raise start for one cycle with the given operands.
  task automatic pulse_start(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] n);
    @(negedge clk);
    bus.m_in  = m;
    bus.n_in  = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait for a done pulse, with a bounded number of cycles.
  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < LAT + 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.m_in = '0; bus.n_in = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.quot !== 16'h0000) $display("FAIL reset_quot: got %h want 0000", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0000) $display("FAIL reset_rem: got %h want 0000", bus.rem); else n_pass++;
    n_checks++; if (bus.dz !== 1'b0) $display("FAIL reset_dz: got %b want 0", bus.dz); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_after_reset: busy %b want 0", bus.busy); else n_pass++;
  endtask

  // Start is held high for 3 cycles and must still launch only one operation.
  task automatic test_single_launch();
    int bcnt = 0, dcnt = 0, last_busy = -1, done_idx = -1;
    logic first_busy = 1'b0, busy_at_done = 1'b1, z = 1'b1;
    logic [WIDTH-1:0] q = '0, r = '0;
    @(negedge clk);
    bus.m_in = 16'h00CD; bus.n_in = 16'h00AB; bus.start = 1'b1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = bus.busy;
      if (i == 2) bus.start = 1'b0;
      if (bus.busy) begin bcnt++; last_busy = i; end
      if (bus.done) begin dcnt++; done_idx = i; q = bus.quot; r = bus.rem; z = bus.dz; busy_at_done = bus.busy; end
    end
    n_checks++; if (first_busy !== 1'b1) $display("FAIL launch_busy: got %b want 1", first_busy); else n_pass++;
    n_checks++; if (bcnt != LAT) $display("FAIL busy_cycles: got %0d want %0d", bcnt, LAT); else n_pass++;
    n_checks++; if (dcnt != 1) $display("FAIL done_pulses: got %0d want 1", dcnt); else n_pass++;
    n_checks++; if (done_idx != last_busy + 1) $display("FAIL done_timing: done at %0d want %0d", done_idx, last_busy + 1); else n_pass++;
    n_checks++; if (busy_at_done !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy_at_done); else n_pass++;
    n_checks++; if (q !== 16'h0001) $display("FAIL single_quot: got %h want 0001", q); else n_pass++;
    n_checks++; if (r !== 16'h0022) $display("FAIL single_rem: got %h want 0022", r); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL single_dz: got %b want 0", z); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ok;
    pulse_start(16'd100, 16'd7);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b1_timeout: done %b want 1", ok); else n_pass++;
    n_checks++; if (bus.quot !== 16'h000E) $display("FAIL b2b1_quot: got %h want 000E", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0002) $display("FAIL b2b1_rem: got %h want 0002", bus.rem); else n_pass++;
    bus.m_in = 16'hFFFF; bus.n_in = 16'h0001; bus.start = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: busy %b want 1", bus.busy); else n_pass++;
    bus.start = 1'b0;
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL b2b2_timeout: done %b want 1", ok); else n_pass++;
    n_checks++; if (bus.quot !== 16'hFFFF) $display("FAIL b2b2_quot: got %h want FFFF", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0000) $display("FAIL b2b2_rem: got %h want 0000", bus.rem); else n_pass++;
  endtask

  // A second start arrives mid-operation. It must be dropped, and the results
  // must hold their previous values (FFFF/0000) until completion.
  task automatic test_ignore_while_busy();
    logic hold_ok = 1'b1, seen = 1'b0;
    int extra = 0;
    pulse_start(16'h00CD, 16'h00AB);
    for (int i = 1; i < LAT + 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 4) begin bus.m_in = 16'h1234; bus.n_in = 16'h0003; bus.start = 1'b1; end
      if (i == 5) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
      else if (bus.quot !== 16'hFFFF || bus.rem !== 16'h0000) hold_ok = 1'b0;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL ign_timeout: done %b want 1", seen); else n_pass++;
    n_checks++; if (hold_ok !== 1'b1) $display("FAIL ign_hold: results changed early (%b) want 1", hold_ok); else n_pass++;
    n_checks++; if (bus.quot !== 16'h0001) $display("FAIL ign_quot: got %h want 0001", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0022) $display("FAIL ign_rem: got %h want 0022", bus.rem); else n_pass++;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra++;
    end
    n_checks++; if (extra != 0) $display("FAIL ign_queued: got %0d busy/done cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic ok;
    pulse_start(16'h1234, 16'h0000);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL dz_timeout: done %b want 1", ok); else n_pass++;
    n_checks++; if (bus.quot !== 16'hFFFF) $display("FAIL dz_quot: got %h want FFFF", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h1234) $display("FAIL dz_rem: got %h want 1234", bus.rem); else n_pass++;
    n_checks++; if (bus.dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", bus.dz); else n_pass++;
    pulse_start(16'd100, 16'd7);
    wait_done(ok);
    n_checks++; if (bus.dz !== 1'b0) $display("FAIL dz_clear: got %b want 0", bus.dz); else n_pass++;
    n_checks++; if (bus.quot !== 16'h000E) $display("FAIL dz_next_quot: got %h want 000E", bus.quot); else n_pass++;
  endtask

  task automatic test_zero_dividend();
    logic ok;
    pulse_start(16'h0000, 16'h0005);
    wait_done(ok);
    n_checks++; if (bus.quot !== 16'h0000) $display("FAIL zero_quot: got %h want 0000", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0000) $display("FAIL zero_rem: got %h want 0000", bus.rem); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic ok;
    int stray = 0;
    pulse_start(16'h1234, 16'h0000);
    wait_done(ok);
    pulse_start(16'h00CD, 16'h00AB);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL abort_done: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.quot !== 16'h0000) $display("FAIL abort_quot: got %h want 0000", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'h0000) $display("FAIL abort_rem: got %h want 0000", bus.rem); else n_pass++;
    n_checks++; if (bus.dz !== 1'b0) $display("FAIL abort_dz: got %b want 0", bus.dz); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL abort_stray: got %0d busy/done cycles want 0", stray); else n_pass++;
    pulse_start(16'd100, 16'd7);
    wait_done(ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL abort_restart: done %b want 1", ok); else n_pass++;
    n_checks++; if (bus.quot !== 16'h000E || bus.rem !== 16'h0002)
      $display("FAIL abort_restart_result: got %h/%h want 000E/0002", bus.quot, bus.rem); else n_pass++;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic ok;
    int bcnt;
    pulse_start(16'hFF9C, 16'h0007);
    bcnt = bus.busy ? 1 : 0;
    ok = 1'b0;
    for (int i = 0; i < LAT + 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) ok = 1'b1;
    end
    n_checks++; if (bcnt != WIDTH + 1) $display("FAIL sgn_busy_cycles: got %0d want %0d", bcnt, WIDTH + 1); else n_pass++;
    n_checks++; if (bus.quot !== 16'hFFF2) $display("FAIL sgn_quot: got %h want FFF2", bus.quot); else n_pass++;
    n_checks++; if (bus.rem !== 16'hFFFE) $display("FAIL sgn_rem: got %h want FFFE", bus.rem); else n_pass++;
    pulse_start(16'd100, 16'hFFF9);
    wait_done(ok);
    n_checks++; if (bus.quot !== 16'hFFF2 || bus.rem !== 16'h0002)
      $display("FAIL sgn_negdiv: got %h/%h want FFF2/0002", bus.quot, bus.rem); else n_pass++;
    pulse_start(16'h8000, 16'hFFFF);
    wait_done(ok);
    n_checks++; if (bus.quot !== 16'h8000 || bus.rem !== 16'h0000 || bus.dz !== 1'b0)
      $display("FAIL sgn_wrap: got %h/%h dz %b want 8000/0000 dz 0", bus.quot, bus.rem, bus.dz); else n_pass++;
    pulse_start(16'hFF9C, 16'h0000);
    wait_done(ok);
    n_checks++; if (bus.quot !== 16'hFFFF || bus.rem !== 16'hFF9C || bus.dz !== 1'b1)
      $display("FAIL sgn_dz: got %h/%h dz %b want FFFF/FF9C dz 1", bus.quot, bus.rem, bus.dz); else n_pass++;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.m_in  = '0;
    bus.n_in  = '0;
    test_reset();
    test_single_launch();
    test_back_to_back();
    test_ignore_while_busy();
    test_div_zero();
    test_zero_dividend();
    test_reset_abort();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
